// File: rtl/keypad_display_pkg.sv
// Shared key indices, digit codes, FSM states and 7-segment patterns for the
// keypad entry display.
package keypad_pkg;

  localparam int unsigned KEY_STAR = 9;
  localparam int unsigned KEY_ZERO = 10;
  localparam int unsigned KEY_HASH = 11;
  localparam int unsigned NUM_KEYS = 12;
  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {
    ENTRY = 1'b0,
    DONE  = 1'b1
  } kp_state_e;

  // seg[6:0] = {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/keypad_display_if.sv
// Key-event input and display output bundle between the keypad scanner side
// and the 7-segment driver.
interface keypad_display_if;
  logic        valid;
  logic [11:0] Scan_data;
  logic [6:0]  seg1;
  logic [6:0]  seg2;
  logic [6:0]  seg3;
  logic [6:0]  seg4;
  logic [6:0]  seg5;
  logic [6:0]  seg6;
  logic [6:0]  seg7;
  logic [6:0]  seg8;
  logic        Out_en;

  modport master (
    output valid, Scan_data,
    input  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8, Out_en
  );

  modport slave (
    input  valid, Scan_data,
    output seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8, Out_en
  );
endinterface

// File: rtl/keypad_display_seg7_decoder.sv
// Digit-slot code to 7-segment pattern; anything outside 0-9 shows blank.
module seg7_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/keypad_display.sv
// Keypad entry buffer: one-hot key events fill an 8-digit shift buffer shown on
// eight 7-segment digits; '*' clears, '#' commits and raises Out_en.
//   state | meaning
//   ENTRY | collecting digits, Out_en low
//   DONE  | entry committed by '#', Out_en high until next digit or '*'
module keypad_display
  import keypad_pkg::*;
(
  input logic             clk,
  input logic             rst,
  keypad_display_if.slave bus
);

  localparam logic [NUM_DIGITS-1:0][3:0] ALL_BLANK = {NUM_DIGITS{BLANK}};

  kp_state_e                   state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]  slot_q, slot_d;
  logic                        out_en_q, out_en_d;

  logic       key_ok;
  logic       is_star;
  logic       is_hash;
  logic       is_digit;
  logic [3:0] digit;

  // Malformed scanner codes (zero or multi-hot) are dropped here.
  always_comb begin
    key_ok   = bus.valid && $onehot(bus.Scan_data);
    is_star  = bus.Scan_data[KEY_STAR];
    is_hash  = bus.Scan_data[KEY_HASH];
    is_digit = |{bus.Scan_data[8:0], bus.Scan_data[KEY_ZERO]};
    digit    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (bus.Scan_data[i]) digit = 4'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ENTRY;
      slot_q   <= ALL_BLANK;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      out_en_q <= out_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    out_en_d = out_en_q;
    if (key_ok) begin
      unique case (state_q)
        ENTRY: begin
          if (is_star) begin
            slot_d = ALL_BLANK;
          end else if (is_hash) begin
            out_en_d = 1'b1;
            state_d  = DONE;
          end else if (is_digit) begin
            slot_d = {slot_q[NUM_DIGITS-2:0], digit};
          end
        end
        DONE: begin
          if (is_star) begin
            slot_d   = ALL_BLANK;
            out_en_d = 1'b0;
            state_d  = ENTRY;
          end else if (is_digit) begin
            slot_d   = {ALL_BLANK[NUM_DIGITS-2:0], digit};
            out_en_d = 1'b0;
            state_d  = ENTRY;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  logic [6:0] seg_w [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_decoder u_dec (
      .code (slot_q[i]),
      .seg  (seg_w[i])
    );
  end

  assign bus.seg1   = seg_w[0];
  assign bus.seg2   = seg_w[1];
  assign bus.seg3   = seg_w[2];
  assign bus.seg4   = seg_w[3];
  assign bus.seg5   = seg_w[4];
  assign bus.seg6   = seg_w[5];
  assign bus.seg7   = seg_w[6];
  assign bus.seg8   = seg_w[7];
  assign bus.Out_en = out_en_q;

endmodule

// File: tb/tb_keypad_display.sv
// Scoreboard bench for keypad_display: a queue-of-digits reference model
// predicts the display after every clock edge that carries a key event.
module tb_keypad_display;

  logic clk = 1'b0;
  logic rst;

  keypad_display_if bus ();

  keypad_display dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic            out_en;
  } exp_t;

  localparam logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: digits entered so far, oldest first, plus commit flag.
  int mdl_q[$];
  bit mdl_done;

  function automatic exp_t model_view();
    exp_t e;
    int   idx;
    e.out_en = mdl_done;
    for (int k = 0; k < 8; k++) begin
      idx = mdl_q.size() - 1 - k;
      e.seg[k] = (idx >= 0) ? PAT[mdl_q[idx]] : 7'b0000000;
    end
    return e;
  endfunction

  function automatic void model_apply(input logic v, input logic [11:0] d);
    int k;
    if (!v || $countones(d) != 1) return;
    k = 0;
    for (int i = 0; i < 12; i++) if (d[i]) k = i;
    if (k == 9) begin
      mdl_q.delete();
      mdl_done = 1'b0;
    end else if (k == 11) begin
      mdl_done = 1'b1;
    end else begin
      if (mdl_done) begin
        mdl_q.delete();
        mdl_done = 1'b0;
      end
      mdl_q.push_back((k == 10) ? 0 : k + 1);
      if (mdl_q.size() > 8) void'(mdl_q.pop_front());
    end
  endfunction

  function automatic logic [55:0] dut_segs();
    return {bus.seg8, bus.seg7, bus.seg6, bus.seg5,
            bus.seg4, bus.seg3, bus.seg2, bus.seg1};
  endfunction

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (dut_segs() !== e.seg) begin
      failures++;
      $display("FAIL %s segs: got %h expected %h", name, dut_segs(), e.seg);
    end
    checks++;
    if (bus.Out_en !== e.out_en) begin
      failures++;
      $display("FAIL %s Out_en: got %b expected %b", name, bus.Out_en, e.out_en);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", e);
      end
    end
  endtask

  // Present a key for n consecutive rising edges; each edge gets a prediction.
  task automatic send(input logic v, input logic [11:0] d, input int n = 1);
    @(negedge clk);
    bus.valid     = v;
    bus.Scan_data = d;
    repeat (n) begin
      @(posedge clk);
      model_apply(v, d);
      exp_q.push_back(model_view());
    end
    #1;
    bus.valid     = 1'b0;
    bus.Scan_data = 12'h000;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [11:0] d;
    logic        v;
    int          r;

    rst           = 1'b0;
    bus.valid     = 1'b0;
    bus.Scan_data = 12'h000;
    mdl_q.delete();
    mdl_done = 1'b0;

    fork
      monitor();
    join_none

    #12;
    compare("reset_held", model_view());
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare("reset_release", model_view());

    // Directed walk through the commit / clear rules.
    send(1'b1, 12'h001);
    send(1'b1, 12'h800);
    send(1'b1, 12'h002);
    send(1'b1, 12'h400);
    send(1'b1, 12'h800);
    send(1'b1, 12'h200);
    send(1'b1, 12'h800);
    send(1'b1, 12'h800);
    for (int i = 0; i < 9; i++) send(1'b1, 12'(1) << i);
    send(1'b1, 12'h003);
    send(1'b1, 12'h000);
    send(1'b0, 12'h010);
    send(1'b1, 12'h010, 3);
    drain();

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 70) begin
        d = 12'(1) << $urandom_range(0, 11);
      end else if (r < 80) begin
        d = 12'h000;
      end else if (r < 90) begin
        d = 12'($urandom);
        while ($countones(d) < 2) d = 12'($urandom);
      end else begin
        v = 1'b0;
        d = 12'(1) << $urandom_range(0, 11);
      end
      send(v, d, ($urandom_range(0, 9) == 0) ? 2 : 1);
    end
    drain();

    // Make sure the display is populated, then reset between edges.
    send(1'b1, 12'h080);
    send(1'b1, 12'h800);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b0;
    mdl_q.delete();
    mdl_done = 1'b0;
    #1;
    compare("async_reset", model_view());
    @(negedge clk);
    rst = 1'b1;
    send(1'b1, 12'h004);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
